// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues in-order word fetches under a credit limit and buffers responses for decode.
// Optional IFETCH_MISALIGN_TRAP_EN: misaligned redirect raises fetch_fault and blocks fetching instead of aligning the target.
module ifetch_queue #(
  parameter int          DEPTH        = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW+1:0] DEPTH_L = (CW+2)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_q_head;
  logic [AW-1:0] r_q_tail;
  logic [AW-1:0] r_af_head;
  logic [AW-1:0] r_af_tail;
  logic          r_fault;

  logic [31:0] r_q_data [DEPTH];
  logic [31:0] r_q_pc   [DEPTH];
  logic [31:0] r_af     [DEPTH];

  logic [31:0]   w_redirect_pc;
  logic          w_misaligned;
  logic [CW+1:0] w_occ;
  logic          w_fire;
  logic          w_pop;
  logic          w_push;
  logic          w_rsp_drop;
  logic          w_rsp_inflight;
  logic [CW-1:0] w_drop_redirect;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign w_redirect_pc = redirect_pc;
  assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
`else
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_misaligned  = 1'b0;
`endif

  // Credit covers queued entries, live requests and stale responses still to be discarded.
  assign w_occ          = (CW+2)'(r_count) + (CW+2)'(r_out) + (CW+2)'(r_drop);
  assign imem_req_valid = !rst && !redirect && !r_fault && (w_occ < DEPTH_L);
  assign imem_req_addr  = r_fetch_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;

  assign inst_valid = (r_count != '0);
  assign inst_data  = inst_valid ? r_q_data[r_q_head] : 32'h0;
  assign inst_pc    = inst_valid ? r_q_pc[r_q_head]   : 32'h0;
  assign w_pop      = inst_valid && inst_ready && !redirect;

  assign w_rsp_inflight = (r_drop != '0) || (r_out != '0);
  assign w_rsp_drop     = imem_rsp_valid && (r_drop != '0);
  assign w_push         = imem_rsp_valid && (r_drop == '0) && (r_out != '0) && !redirect && !rst;
  // A response landing in the redirect cycle belongs to the flushed stream.
  assign w_drop_redirect = r_drop + r_out - CW'(imem_rsp_valid && w_rsp_inflight);

  assign fetch_fault = r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_VECTOR;
      r_count    <= '0;
      r_out      <= '0;
      r_drop     <= '0;
      r_q_head   <= '0;
      r_q_tail   <= '0;
      r_af_head  <= '0;
      r_af_tail  <= '0;
      r_fault    <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_count    <= '0;
      r_out      <= '0;
      r_drop     <= w_drop_redirect;
      r_q_head   <= '0;
      r_q_tail   <= '0;
      r_af_head  <= '0;
      r_af_tail  <= '0;
      r_fault    <= w_misaligned;
    end else begin
      if (w_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_af_tail  <= r_af_tail + 1'b1;
      end
      if (w_push) begin
        r_q_tail  <= r_q_tail + 1'b1;
        r_af_head <= r_af_head + 1'b1;
      end
      if (w_pop) begin
        r_q_head <= r_q_head + 1'b1;
      end
      if (w_rsp_drop) begin
        r_drop <= r_drop - 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_out   <= r_out + CW'(w_fire) - CW'(w_push);
    end
  end

  // Storage arrays carry no reset; validity comes from the pointers and counters above.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_af[r_af_tail] <= r_fetch_pc;
    end
    if (w_push) begin
      r_q_data[r_q_tail] <= imem_rsp_data;
      r_q_pc[r_q_tail]   <= r_af[r_af_head];
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_ifetch_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        fetch_fault;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: memory-side queue of accepted addresses (oldest first),
  // number of leading stale entries, and decode-side queue of buffered PCs.
  logic [31:0] mem_q[$];
  logic [31:0] iq_pc[$];
  int          m_drop = 0;
  logic [31:0] m_pc = 32'h0;
  logic        m_fault = 1'b0;
  bit          m_known = 1'b0;

  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit i_rst, input bit i_redir, input logic [31:0] i_rpc,
                      input bit i_rdy, input bit i_irdy, input bit i_rsp_en, input bit i_stray);
    bit          rsp_fire;
    bit          exp_valid;
    logic [31:0] a;
    @(negedge clk);
    rst            = i_rst;
    redirect       = i_redir;
    redirect_pc    = i_rpc;
    imem_req_ready = i_rdy;
    inst_ready     = i_irdy;
    rsp_fire       = i_rsp_en && (mem_q.size() > 0);
    imem_rsp_valid = rsp_fire || i_stray;
    imem_rsp_data  = rsp_fire ? memf(mem_q[0]) : $urandom;
    #1;
    exp_valid = !i_rst && !i_redir && !m_fault && ((iq_pc.size() + mem_q.size()) < DEPTH);
    if (m_known) begin
      chk("req_valid", imem_req_valid, exp_valid);
      if (exp_valid) chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", inst_valid, iq_pc.size() != 0);
      if (iq_pc.size() != 0) begin
        chk("inst_pc", inst_pc, iq_pc[0]);
        chk("inst_data", inst_data, memf(iq_pc[0]));
      end
      chk("fetch_fault", fetch_fault, m_fault);
      $display("cyc rst=%0b redir=%0b req=%0b addr=%h ivalid=%0b ipc=%h", i_rst, i_redir,
               imem_req_valid, imem_req_addr, inst_valid, inst_pc);
    end
    if (imem_req_valid && i_rdy) acc_log.push_back(imem_req_addr);
    if (inst_valid && i_irdy && !i_redir && !i_rst) pop_log.push_back(inst_pc);

    if (i_rst) begin
      mem_q.delete(); iq_pc.delete();
      m_drop = 0; m_pc = 32'h0; m_fault = 1'b0; m_known = 1'b1;
    end else if (i_redir) begin
      if (rsp_fire) void'(mem_q.pop_front());
      m_drop = mem_q.size();
      iq_pc.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
      m_pc    = i_rpc;
      m_fault = (i_rpc[1:0] != 2'b00);
`else
      m_pc    = i_rpc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (i_irdy && iq_pc.size() != 0) void'(iq_pc.pop_front());
      if (rsp_fire) begin
        a = mem_q.pop_front();
        if (m_drop > 0) m_drop--;
        else iq_pc.push_back(a);
      end
      if (exp_valid && i_rdy) begin
        mem_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    acc_log.delete();
    pop_log.delete();
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clk); #1;
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", fetch_fault, 1'b0);

    // Streaming with a 1-cycle memory
    do_reset();
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 1, 0);
    chk("stream_nacc", acc_log.size() >= 3, 1);
    chk("stream_npop", pop_log.size() >= 3, 1);
    for (int i = 0; i < 3; i++) begin
      chk("stream_acc", acc_log[i], 32'(4 * i));
      chk("stream_pop", pop_log[i], 32'(4 * i));
    end

    // Decode stalled: credit stops requests at DEPTH
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 1, 0);
    chk("stall_nacc", acc_log.size(), DEPTH);
    chk("stall_req_low", imem_req_valid, 1'b0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 1, 1, 0);
    chk("stall_resume", acc_log.size() >= 3, 1);

    // Redirect with two requests outstanding
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
    chk("redir_outstanding", acc_log.size(), 2);
    acc_log.delete(); pop_log.delete();
    step(0, 1, 32'h100, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1, 0);
    chk("redir_npop", pop_log.size() >= 1, 1);
    chk("redir_first_pop", pop_log[0], 32'h100);
    chk("redir_first_acc", acc_log[0], 32'h100);

    // Memory back-pressure holds the address
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 1, 0);
      chk("hold_addr", imem_req_addr, 32'h0);
    end

    // Address wrap at the top of memory
    do_reset();
    step(0, 1, 32'hFFFF_FFFC, 1, 1, 1, 0);
    acc_log.delete();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1, 0);
    chk("wrap_n", acc_log.size() >= 2, 1);
    chk("wrap_acc0", acc_log[0], 32'hFFFF_FFFC);
    chk("wrap_acc1", acc_log[1], 32'h0);

    // Misaligned redirect
    do_reset();
    step(0, 1, 32'h102, 1, 1, 1, 0);
    acc_log.delete();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("mis_fault", fetch_fault, 1'b1);
    chk("mis_noreq", acc_log.size(), 0);
    step(0, 1, 32'h200, 1, 1, 1, 0);
    acc_log.delete();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0);
    chk("mis_clear", fetch_fault, 1'b0);
    chk("mis_realign", acc_log[0], 32'h200);
`else
    chk("mis_n", acc_log.size() >= 1, 1);
    chk("mis_aligned", acc_log[0], 32'h100);
`endif

    // Stray response with nothing outstanding is ignored
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("stray_ignored", inst_valid, 1'b0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bit          r_rst;
      bit          r_red;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 199) == 0);
      r_red = ($urandom_range(0, 15) == 0);
      r_pc  = $urandom;
      if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
      step(r_rst, r_red, r_pc, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
